lsq_mem_sched: RTL and testbench
================================

# lsq_mem_sched

Single-port data-memory scheduler between the load/store queue and data memory. It arbitrates resolved loads against retired, committed stores, keeps one memory transaction in flight, and returns load data and store acknowledgements to the LSQ tagged by PC. A starvation counter bounds how long a waiting store can be held off by loads. Flush support drops wrong-path load responses.

## Interface
- PC_W, 32, PC tag width
- ADDR_W, 32, memory address width
- DATA_W, 32, data width
- STARVE_MAX, 4, maximum consecutive load wins while a store waits (1..15)

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous, active-low reset
- ldValid  in  1  LSQ offers a load with resolved address
- ldPc / ldAddr  in  PC_W / ADDR_W  load tag and address
- ldReady  out  1  load accepted when ldValid&ldReady
- stValid  in  1  LSQ offers a retired store
- stPc / stAddr / stData  in  PC_W / ADDR_W / DATA_W  store tag, address, data
- stReady  out  1  store accepted when stValid&stReady
- memReq  out  1  request to memory
- memWe  out  1  1=store, 0=load
- memAddr / memWdata  out  ADDR_W / DATA_W  request address and write data
- memGnt  in  1  memory accepts memReq this cycle
- memRvalid  in  1  response: load data or store ack
- memRdata  in  DATA_W  load data
- ldDoneValid  out  1  one-cycle pulse, load complete
- ldDonePc / ldDoneData  out  PC_W / DATA_W  completed load tag and data
- stDoneValid  out  1  one-cycle pulse, store written
- stDonePc  out  PC_W  completed store tag
- flush  in  1  squash the in-flight or offered load
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, REQ, WAIT.
- In IDLE, ldReady and stReady are combinational; at most one is high. Both are 0 outside IDLE.
- Arbitration in IDLE:
  - Only one side valid: that side wins.
  - Both valid: store wins if starveCnt == STARVE_MAX, otherwise load wins.
  - flush forces ldReady=0.
- starveCnt:
  - +1 (saturating at STARVE_MAX) when a load is accepted while stValid=1.
  - Cleared when a store is accepted.
- Handshake in IDLE latches the op, PC, address and data, then goes to REQ.
- REQ:
  - memReq=1, with memWe/memAddr/memWdata stable until memGnt.
  - memGnt=1 → WAIT.
- WAIT: memReq=0. memRvalid=1 → IDLE and pulse the matching done output one cycle later.
- memRvalid outside WAIT is ignored.
- Flush, loads only (stores are retired and never flushed):
  - Load in REQ, memGnt=0: abort to IDLE. No done pulse.
  - Load in REQ, memGnt=1 same cycle: go to WAIT with drop=1.
  - Load in WAIT: set drop=1.
  - drop=1: the response is consumed with no ldDoneValid, then drop clears.
- Widths are fixed by parameters. No arithmetic on data or address.

## Timing
- Reset: state IDLE, starveCnt 0, drop 0. All outputs 0, including memReq, done pulses, tags, data and busy.
- Reset asserted mid-transaction abandons it immediately. No done pulse is issued.
- Accept at edge N → memReq=1 in cycle N+1.
- memGnt in cycle G → WAIT from G+1.
- memRvalid in cycle R → done pulse and ldDoneData=memRdata registered in R+1. IDLE in R+1, which can accept a new op the same cycle.
- Minimum throughput: 3 cycles per op, with gnt on the first REQ cycle and rvalid on the first WAIT cycle.
- Done tag and data outputs hold their last value between pulses.

## Structure
- Shared package lsq_pkg:
  - state enum {IDLE, REQ, WAIT}
  - op encoding (OP_LD=0, OP_ST=1)
  - default width constants
- One sub-module, lsq_mem_pick: starvation counter plus winner select. Inputs: ldValid, stValid, flush, idle, accept. Outputs: pickSt, ldReady, stReady.

## Test plan
- Single load: ldPc=0x2, ldAddr=0x12. Memory grants immediately and returns 0xCAFE next cycle → memReq with memWe=0, memAddr=0x12; then ldDoneValid with ldDonePc=0x2, ldDoneData=0xCAFE, 3 cycles after accept.
- Store then load: stPc=0x1, stAddr=0x12, stData=0x1234, then a load to 0x12 → memWdata=0x1234 with memWe=1; stDoneValid with stDonePc=0x1 before the load issues.
- Starvation, STARVE_MAX=4: continuous ldValid, stValid held with stPc=0x5 → 4 loads accepted, then the store. starveCnt returns to 0.
- Grant stall: memGnt low for 5 cycles → memReq and request fields stable all 5 cycles, ldReady/stReady stay 0, busy=1.
- Flush in WAIT (load 0x3 in flight) → response consumed with no ldDoneValid; the next offered load is accepted normally. Flush during a store → stDoneValid still pulses.
- rstn low during WAIT → all outputs 0 immediately. A later memRvalid produces no done pulse.

Source files
------------

// File: rtl/lsq_pkg.sv
// lsq_pkg: shared FSM state, op encoding and default widths for the LSQ memory scheduler.
package lsq_pkg;
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
    typedef enum logic {OP_LD = 1'b0, OP_ST = 1'b1} op_t;
    localparam int PC_W_DEF = 32;
    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int STARVE_MAX_DEF = 4;
endpackage

// File: rtl/lsq_mem_sched_if.sv
// lsq_mem_sched_if: LSQ offer/done and data-memory request/response signals of the scheduler.
interface lsq_mem_sched_if import lsq_pkg::*; #(
    parameter int PC_W = PC_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic ldValid, ldReady, stValid, stReady, flush, busy;
    logic [PC_W-1:0] ldPc, stPc, ldDonePc, stDonePc;
    logic [ADDR_W-1:0] ldAddr, stAddr, memAddr;
    logic [DATA_W-1:0] stData, memWdata, memRdata, ldDoneData;
    logic memReq, memWe, memGnt, memRvalid, ldDoneValid, stDoneValid;
    modport slave (
        input ldValid, ldPc, ldAddr, stValid, stPc, stAddr, stData, memGnt, memRvalid, memRdata, flush,
        output ldReady, stReady, memReq, memWe, memAddr, memWdata, ldDoneValid, ldDonePc, ldDoneData,
        stDoneValid, stDonePc, busy
    );
    modport master (
        output ldValid, ldPc, ldAddr, stValid, stPc, stAddr, stData, memGnt, memRvalid, memRdata, flush,
        input ldReady, stReady, memReq, memWe, memAddr, memWdata, ldDoneValid, ldDonePc, ldDoneData,
        stDoneValid, stDonePc, busy
    );
endinterface

// File: rtl/lsq_mem_pick.sv
// lsq_mem_pick: load/store winner select with a saturating counter of loads that overtook a waiting store.
module lsq_mem_pick import lsq_pkg::*; #(
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic clk,
    input  logic rstn,
    input  logic ldValid,
    input  logic stValid,
    input  logic flush,
    input  logic idle,
    input  logic accept,
    output logic pickSt,
    output logic ldReady,
    output logic stReady
);
    logic [3:0] starve_q, starve_d;
    logic ld_elig;
    // A flushed load is not a candidate, so a waiting store takes the slot instead.
    always_comb begin
        ld_elig = ldValid & ~flush;
        pickSt = stValid & (~ld_elig | (starve_q == 4'(STARVE_MAX)));
        ldReady = idle & ld_elig & ~pickSt;
        stReady = idle & pickSt;
        starve_d = starve_q;
        if (accept & pickSt) starve_d = '0;
        else if (accept & stValid & (starve_q != 4'(STARVE_MAX))) starve_d = starve_q + 4'd1;
    end
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) starve_q <= '0;
        else starve_q <= starve_d;
endmodule

// File: rtl/lsq_mem_sched.sv
// lsq_mem_sched: single-port data-memory scheduler; one transaction in flight, done pulses
// registered one cycle after the memory response, wrong-path load responses dropped on flush.
module lsq_mem_sched import lsq_pkg::*; #(
    parameter int PC_W = PC_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input logic clk,
    input logic rstn,
    lsq_mem_sched_if.slave bus
);
    state_t state_q, state_d;
    op_t op_q, op_d;
    logic [PC_W-1:0] pc_q, pc_d, ld_pc_q, ld_pc_d, st_pc_q, st_pc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d, ld_data_q, ld_data_d;
    logic drop_q, drop_d, ld_dv_q, ld_dv_d, st_dv_q, st_dv_d;
    logic idle, accept, pick_st, ld_flush;
    assign idle = state_q == IDLE;
    assign accept = (bus.ldValid & bus.ldReady) | (bus.stValid & bus.stReady);
    lsq_mem_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
        .clk(clk), .rstn(rstn), .ldValid(bus.ldValid), .stValid(bus.stValid), .flush(bus.flush),
        .idle(idle), .accept(accept), .pickSt(pick_st), .ldReady(bus.ldReady), .stReady(bus.stReady)
    );
    always_comb begin
        state_d = state_q;
        op_d = op_q;
        pc_d = pc_q;
        addr_d = addr_q;
        data_d = data_q;
        drop_d = drop_q;
        ld_dv_d = 1'b0;
        st_dv_d = 1'b0;
        ld_pc_d = ld_pc_q;
        ld_data_d = ld_data_q;
        st_pc_d = st_pc_q;
        ld_flush = bus.flush & (op_q == OP_LD);
        case (state_q)
            IDLE: if (accept) begin
                state_d = REQ;
                op_d = pick_st ? OP_ST : OP_LD;
                pc_d = pick_st ? bus.stPc : bus.ldPc;
                addr_d = pick_st ? bus.stAddr : bus.ldAddr;
                data_d = pick_st ? bus.stData : '0;
            end
            REQ: if (bus.memGnt) begin
                state_d = WAIT;
                drop_d = ld_flush;
            end else if (ld_flush) state_d = IDLE;
            WAIT: begin
                drop_d = drop_q | ld_flush;
                if (bus.memRvalid) begin
                    state_d = IDLE;
                    drop_d = 1'b0;
                    ld_dv_d = (op_q == OP_LD) & ~(drop_q | ld_flush);
                    st_dv_d = op_q == OP_ST;
                    ld_pc_d = ld_dv_d ? pc_q : ld_pc_q;
                    ld_data_d = ld_dv_d ? bus.memRdata : ld_data_q;
                    st_pc_d = st_dv_d ? pc_q : st_pc_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            state_q <= IDLE;
            op_q <= OP_LD;
            pc_q <= '0;
            addr_q <= '0;
            data_q <= '0;
            drop_q <= 1'b0;
            ld_dv_q <= 1'b0;
            st_dv_q <= 1'b0;
            ld_pc_q <= '0;
            ld_data_q <= '0;
            st_pc_q <= '0;
        end else begin
            state_q <= state_d;
            op_q <= op_d;
            pc_q <= pc_d;
            addr_q <= addr_d;
            data_q <= data_d;
            drop_q <= drop_d;
            ld_dv_q <= ld_dv_d;
            st_dv_q <= st_dv_d;
            ld_pc_q <= ld_pc_d;
            ld_data_q <= ld_data_d;
            st_pc_q <= st_pc_d;
        end
    assign bus.memReq = state_q == REQ;
    assign bus.memWe = op_q == OP_ST;
    assign bus.memAddr = addr_q;
    assign bus.memWdata = data_q;
    assign bus.ldDoneValid = ld_dv_q;
    assign bus.ldDonePc = ld_pc_q;
    assign bus.ldDoneData = ld_data_q;
    assign bus.stDoneValid = st_dv_q;
    assign bus.stDonePc = st_pc_q;
    assign bus.busy = ~idle;
endmodule

// File: tb/tb_lsq_mem_sched.sv
// tb_lsq_mem_sched: transaction-level reference model checked every cycle under directed and random traffic,
// plus literal expectations from the scheduler's documented scenarios.
module tb_lsq_mem_sched;
    import lsq_pkg::*;
    localparam int SM = 4;
    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;
    lsq_mem_sched_if bus();
    lsq_mem_sched #(.STARVE_MAX(SM)) dut (.clk(clk), .rstn(rstn), .bus(bus));
    int vectors = 0;
    int miscompares = 0;
    // Reference: the single outstanding transaction plus the last reported completions.
    logic m_valid, m_st, m_gnt, m_drop, m_ld_dv, m_st_dv;
    logic [31:0] m_pc, m_addr, m_data, m_ld_pc, m_ld_data, m_st_pc;
    int m_starve;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        {m_valid, m_st, m_gnt, m_drop, m_ld_dv, m_st_dv} = '0;
        {m_pc, m_addr, m_data, m_ld_pc, m_ld_data, m_st_pc} = '0;
        m_starve = 0;
    endtask

    task automatic quiet();
        bus.ldValid = 0; bus.ldPc = '0; bus.ldAddr = '0;
        bus.stValid = 0; bus.stPc = '0; bus.stAddr = '0; bus.stData = '0;
        bus.memGnt = 0; bus.memRvalid = 0; bus.memRdata = '0; bus.flush = 0;
    endtask

    // Entered at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic cycle();
        logic idle, ld_ok, st_win, e_ldr, e_str;
        #1;
        idle = !m_valid;
        ld_ok = bus.ldValid & !bus.flush;
        st_win = bus.stValid & (!ld_ok | (m_starve == SM));
        e_ldr = idle & ld_ok & !st_win;
        e_str = idle & st_win;
        chk("ldReady", 64'(bus.ldReady), 64'(e_ldr));
        chk("stReady", 64'(bus.stReady), 64'(e_str));
        chk("memReq", 64'(bus.memReq), 64'(m_valid & !m_gnt));
        if (m_valid & !m_gnt) begin
            chk("memWe", 64'(bus.memWe), 64'(m_st));
            chk("memAddr", 64'(bus.memAddr), 64'(m_addr));
            chk("memWdata", 64'(bus.memWdata), 64'(m_data));
        end
        chk("busy", 64'(bus.busy), 64'(m_valid));
        chk("ldDoneValid", 64'(bus.ldDoneValid), 64'(m_ld_dv));
        chk("ldDonePc", 64'(bus.ldDonePc), 64'(m_ld_pc));
        chk("ldDoneData", 64'(bus.ldDoneData), 64'(m_ld_data));
        chk("stDoneValid", 64'(bus.stDoneValid), 64'(m_st_dv));
        chk("stDonePc", 64'(bus.stDonePc), 64'(m_st_pc));
        @(posedge clk);
        m_ld_dv = 0;
        m_st_dv = 0;
        if (idle) begin
            if (e_ldr) begin
                {m_valid, m_st, m_gnt, m_drop} = 4'b1000;
                m_pc = bus.ldPc; m_addr = bus.ldAddr; m_data = '0;
                if (bus.stValid && m_starve < SM) m_starve++;
            end else if (e_str) begin
                {m_valid, m_st, m_gnt, m_drop} = 4'b1100;
                m_pc = bus.stPc; m_addr = bus.stAddr; m_data = bus.stData;
                m_starve = 0;
            end
        end else if (!m_gnt) begin
            if (bus.memGnt) begin
                m_gnt = 1;
                m_drop = !m_st & bus.flush;
            end else if (!m_st & bus.flush) m_valid = 0;
        end else begin
            if (!m_st & bus.flush) m_drop = 1;
            if (bus.memRvalid) begin
                m_valid = 0;
                if (m_st) begin
                    m_st_dv = 1; m_st_pc = m_pc;
                end else if (!m_drop) begin
                    m_ld_dv = 1; m_ld_pc = m_pc; m_ld_data = bus.memRdata;
                end
            end
        end
        @(negedge clk);
    endtask

    // Entered at a falling edge; checks that asynchronous reset clears every output at once.
    task automatic do_reset(input bit lits);
        quiet();
        rstn = 0;
        #1;
        if (lits) begin
            chk("rst_memReq", 64'(bus.memReq), 64'd0);
            chk("rst_memWe", 64'(bus.memWe), 64'd0);
            chk("rst_memAddr", 64'(bus.memAddr), 64'd0);
            chk("rst_memWdata", 64'(bus.memWdata), 64'd0);
            chk("rst_busy", 64'(bus.busy), 64'd0);
            chk("rst_ldDoneValid", 64'(bus.ldDoneValid), 64'd0);
            chk("rst_ldDonePc", 64'(bus.ldDonePc), 64'd0);
            chk("rst_ldDoneData", 64'(bus.ldDoneData), 64'd0);
            chk("rst_stDoneValid", 64'(bus.stDoneValid), 64'd0);
            chk("rst_stDonePc", 64'(bus.stDonePc), 64'd0);
        end
        model_clear();
        @(negedge clk);
        rstn = 1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int nld;
        bit got;
        quiet();
        rstn = 0;
        model_clear();
        repeat (2) @(negedge clk);
        do_reset(1);
        // Single load: accepted, granted at once, data returned on the first WAIT cycle.
        bus.ldValid = 1; bus.ldPc = 32'h2; bus.ldAddr = 32'h12; cycle();
        quiet(); bus.memGnt = 1; #1;
        chk("ld1_memReq", 64'(bus.memReq), 64'd1);
        chk("ld1_memWe", 64'(bus.memWe), 64'd0);
        chk("ld1_memAddr", 64'(bus.memAddr), 64'h12);
        cycle();
        quiet(); bus.memRvalid = 1; bus.memRdata = 32'hCAFE; cycle();
        quiet(); #1;
        chk("ld1_doneValid", 64'(bus.ldDoneValid), 64'd1);
        chk("ld1_donePc", 64'(bus.ldDonePc), 64'h2);
        chk("ld1_doneData", 64'(bus.ldDoneData), 64'hCAFE);
        cycle();
        // Store alone, then a load to the same address waiting behind it.
        bus.stValid = 1; bus.stPc = 32'h1; bus.stAddr = 32'h12; bus.stData = 32'h1234; cycle();
        quiet(); bus.ldValid = 1; bus.ldPc = 32'h7; bus.ldAddr = 32'h12; bus.memGnt = 1; #1;
        chk("st1_memWe", 64'(bus.memWe), 64'd1);
        chk("st1_memWdata", 64'(bus.memWdata), 64'h1234);
        chk("st1_ldReady_busy", 64'(bus.ldReady), 64'd0);
        cycle();
        bus.memGnt = 0; bus.memRvalid = 1; cycle();
        bus.memRvalid = 0; #1;
        chk("st1_doneValid", 64'(bus.stDoneValid), 64'd1);
        chk("st1_donePc", 64'(bus.stDonePc), 64'h1);
        chk("st1_then_ldReady", 64'(bus.ldReady), 64'd1);
        cycle();
        bus.ldValid = 0; bus.memGnt = 1; cycle();
        bus.memGnt = 0; bus.memRvalid = 1; bus.memRdata = 32'h1234; cycle();
        quiet(); cycle();
        // Starvation: loads keep coming; the store must win after SM load wins, twice in a row.
        do_reset(0);
        for (int r = 0; r < 2; r++) begin
            nld = 0;
            got = 0;
            for (int i = 0; i < 60 && !got; i++) begin
                bus.ldValid = 1; bus.ldPc = $urandom; bus.ldAddr = $urandom;
                bus.stValid = 1; bus.stPc = 32'h5; bus.stAddr = 32'h50; bus.stData = 32'h77;
                bus.memGnt = 1; bus.memRvalid = 1; bus.memRdata = $urandom;
                #1;
                if (bus.ldReady) nld++;
                if (bus.stReady) got = 1;
                cycle();
            end
            chk("starve_store_won", 64'(got), 64'd1);
            chk("starve_loads_before_store", 64'(nld), 64'(SM));
        end
        bus.ldValid = 0; bus.stValid = 0;
        repeat (3) cycle();
        // Grant stall for 5 cycles with both sides offering.
        quiet(); bus.ldValid = 1; bus.ldPc = 32'h9; bus.ldAddr = 32'h44; cycle();
        for (int i = 0; i < 5; i++) begin
            bus.ldValid = 1; bus.ldPc = $urandom; bus.stValid = 1; bus.stPc = 32'h6;
            #1;
            chk("stall_memReq", 64'(bus.memReq), 64'd1);
            chk("stall_memAddr", 64'(bus.memAddr), 64'h44);
            chk("stall_memWe", 64'(bus.memWe), 64'd0);
            chk("stall_ldReady", 64'(bus.ldReady), 64'd0);
            chk("stall_stReady", 64'(bus.stReady), 64'd0);
            chk("stall_busy", 64'(bus.busy), 64'd1);
            cycle();
        end
        quiet(); bus.memGnt = 1; cycle();
        quiet(); bus.memRvalid = 1; cycle();
        quiet(); cycle();
        // Flush while a load waits for its response.
        bus.ldValid = 1; bus.ldPc = 32'h3; bus.ldAddr = 32'h30; cycle();
        quiet(); bus.memGnt = 1; cycle();
        quiet(); bus.flush = 1; cycle();
        quiet(); bus.memRvalid = 1; bus.memRdata = 32'hBAD; cycle();
        quiet(); bus.ldValid = 1; bus.ldPc = 32'h4; bus.ldAddr = 32'h40; #1;
        chk("flush_no_ldDone", 64'(bus.ldDoneValid), 64'd0);
        chk("flush_next_ldReady", 64'(bus.ldReady), 64'd1);
        cycle();
        quiet(); bus.memGnt = 1; cycle();
        quiet(); bus.memRvalid = 1; bus.memRdata = 32'h4444; cycle();
        quiet(); #1;
        chk("flush_next_ldDone", 64'(bus.ldDoneValid), 64'd1);
        chk("flush_next_ldPc", 64'(bus.ldDonePc), 64'h4);
        cycle();
        // Flush throughout a store: the store still completes.
        bus.stValid = 1; bus.stPc = 32'hA; bus.stAddr = 32'hA0; bus.stData = 32'h55; cycle();
        quiet(); bus.flush = 1; bus.memGnt = 1; cycle();
        quiet(); bus.flush = 1; bus.memRvalid = 1; cycle();
        quiet(); #1;
        chk("flush_st_done", 64'(bus.stDoneValid), 64'd1);
        chk("flush_st_pc", 64'(bus.stDonePc), 64'hA);
        cycle();
        // Reset asserted while a load waits; a later response must not complete anything.
        bus.ldValid = 1; bus.ldPc = 32'h6; bus.ldAddr = 32'h60; cycle();
        quiet(); bus.memGnt = 1; cycle();
        do_reset(1);
        bus.memRvalid = 1; bus.memRdata = 32'h66; cycle();
        quiet(); #1;
        chk("rst_wait_no_done", 64'(bus.ldDoneValid), 64'd0);
        cycle();
        // Random traffic, with an occasional asynchronous reset.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(299) == 0) do_reset(0);
            bus.ldValid = $urandom_range(9) < 6; bus.ldPc = $urandom; bus.ldAddr = $urandom;
            bus.stValid = $urandom_range(9) < 4; bus.stPc = $urandom; bus.stAddr = $urandom;
            bus.stData = $urandom;
            bus.memGnt = $urandom_range(1); bus.memRvalid = $urandom_range(2) == 0;
            bus.memRdata = $urandom; bus.flush = $urandom_range(11) == 0;
            cycle();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
